// File: rtl/keypad_pkg.sv
// Shared types for the keypad entry block: FSM states, edit-key codes and the
// row/column to key-code map of the 4x4 matrix.
package keypad_pkg;

  typedef enum logic [2:0] {SCAN, PRESS_DEB, COMMIT, HELD, REL_DEB} state_t;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hF;

  // Rows top to bottom: 1 2 3 A | 4 5 6 B | 7 8 9 C | * 0 # D  (* = E, # = F)
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Row synchronizer plus stability counter. The caller picks which rows to watch
// (mask) and the level they must hold; stable rises after DEB_CYCLES in a row.
module keypad_debounce #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  input  logic [3:0] mask,
  input  logic       level,
  input  logic       clear,
  output logic [3:0] row_sync,
  output logic       stable
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [3:0]    meta;
  logic [CW-1:0] cnt;
  logic          cond;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta     <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      meta     <= row;
      row_sync <= meta;
    end
  end

  // level=1: every masked row high; level=0: the masked row low
  assign cond = level ? &(row_sync | ~mask) : ~|(row_sync & mask);

  always_ff @(posedge clk) begin
    if (!rst_n || clear || !cond)
      cnt <= '0;
    else if (cnt != CW'(DEB_CYCLES))
      cnt <= cnt + CW'(1);
  end

  assign stable = cond && (cnt == CW'(DEB_CYCLES));

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner with debounce, assembling decimal keys into a BCD word
// with clear, backspace and enter editing.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              row,
  output logic [3:0]              col,
  output logic [4*NUM_DIGITS-1:0] KP,
  output logic [2:0]              digit_cnt,
  output logic                    key_valid,
  output logic [3:0]              key_code,
  output logic                    entry_done
);

  localparam int KW   = 4 * NUM_DIGITS;
  localparam int SC_W = $clog2(SCAN_DIV + 1);

  state_t          state, state_nx;
  logic [1:0]      col_idx, col_idx_nx, row_idx, row_idx_nx, low_idx;
  logic [SC_W-1:0] scan_cnt, scan_cnt_nx;
  logic [3:0]      row_sync, deb_mask, code;
  logic            stable, scan_last, any_low;

  assign deb_mask  = (state == REL_DEB) ? 4'hF : (4'b0001 << row_idx);
  assign scan_last = (scan_cnt == SC_W'(SCAN_DIV - 1));
  assign any_low   = ~&row_sync;
  assign col       = ~(4'b0001 << col_idx);
  assign code      = key_map(row_idx, col_idx);

  keypad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .mask     (deb_mask),
    .level    (state == REL_DEB),
    .clear    (state != PRESS_DEB && state != REL_DEB),
    .row_sync (row_sync),
    .stable   (stable)
  );

  // Descending scan so the lowest low row is the one left standing
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!row_sync[i]) low_idx = 2'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SCAN;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      scan_cnt <= '0;
    end else begin
      state    <= state_nx;
      col_idx  <= col_idx_nx;
      row_idx  <= row_idx_nx;
      scan_cnt <= scan_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    col_idx_nx  = col_idx;
    row_idx_nx  = row_idx;
    scan_cnt_nx = scan_cnt;
    case (state)
      SCAN: begin
        if (scan_last) begin
          scan_cnt_nx = '0;
          if (any_low) begin
            row_idx_nx = low_idx;
            state_nx   = PRESS_DEB;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end else begin
          scan_cnt_nx = scan_cnt + SC_W'(1);
        end
      end
      PRESS_DEB: begin
        if (row_sync[row_idx]) state_nx = SCAN;
        else if (stable)       state_nx = COMMIT;
      end
      COMMIT:  state_nx = HELD;
      HELD:    if (&row_sync) state_nx = REL_DEB;
      REL_DEB: begin
        if (stable) begin
          state_nx   = SCAN;
          col_idx_nx = col_idx + 2'd1;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      KP         <= '0;
      digit_cnt  <= 3'd0;
      key_valid  <= 1'b0;
      key_code   <= 4'h0;
      entry_done <= 1'b0;
    end else begin
      key_valid  <= (state == COMMIT);
      entry_done <= (state == COMMIT) && (code == KEY_ENT);
      if (state == COMMIT) begin
        key_code <= code;
        if (code <= 4'd9) begin
          if (digit_cnt < 3'(NUM_DIGITS)) begin
            KP        <= {KP[KW-5:0], code};
            digit_cnt <= digit_cnt + 3'd1;
          end
        end else if (code == KEY_CLR) begin
          KP        <= '0;
          digit_cnt <= 3'd0;
        end else if (code == KEY_BS && digit_cnt != 3'd0) begin
          KP        <= {4'h0, KP[KW-1:4]};
          digit_cnt <= digit_cnt - 3'd1;
        end
      end
    end
  end

endmodule
